// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queued J/K command driver for a downstream jk_ff
// Optional expected-q checker enabled by defining JKSEQ_CHECK_EN.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  input  logic             q_fb,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CNT_W;
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  // Command FIFO: pointers carry an extra wrap bit so full and empty differ.
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty, full, push, pop;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len, head_remain;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_op   = head[EW-1 -: 2];
  assign head_len  = head[CNT_W-1:0];
  // A zero length still drives one cycle, so the counter is loaded with len-1.
  assign head_remain = (head_len == '0) ? '0 : head_len - CNT_ONE;

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_len};
    end
  end

  // FIFO pointers; a pop frees its slot for pushes only from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Sequencer FSM state, run counter and registered J/K drive.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             j_q, k_q, j_d, k_d;

  // State register: reset aborts any command and parks J/K at hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  // Next state: the last cycle of a run chains straight into the next command.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d  = RUN;
          remain_d = head_remain;
        end
      end
      RUN: begin
        if (remain_q != '0) begin
          remain_d = remain_q - CNT_ONE;
        end else if (!empty) begin
          remain_d = head_remain;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: FIFO pop strobe and the J/K value registered at this edge.
  always_comb begin
    pop = 1'b0;
    j_d = j_q;
    k_d = k_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head_op;
        end else begin
          {j_d, k_d} = 2'b00;
        end
      end
      RUN: begin
        if (remain_q == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            {j_d, k_d} = head_op;
          end else begin
            {j_d, k_d} = 2'b00;
          end
        end
      end
      default: {j_d, k_d} = 2'b00;
    endcase
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = (state_q == RUN) || !empty;

`ifdef JKSEQ_CHECK_EN
  logic exp_q_q, exp_valid_q, err_q;

  // Expected-q model; checking starts once a SET or RESET has fixed the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q_q     <= 1'b0;
      exp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case ({j_q, k_q})
        2'b01:   exp_q_q <= 1'b0;
        2'b10:   exp_q_q <= 1'b1;
        2'b11:   exp_q_q <= ~exp_q_q;
        default: exp_q_q <= exp_q_q;
      endcase
      if (j_q ^ k_q) exp_valid_q <= 1'b1;
      if (exp_valid_q && (q_fb != exp_q_q)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - randomized self-checking bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             cmd_ready, j, k, busy, q_fb, err;
  logic             q_ff = 1'b1;
  logic             force_q0 = 1'b0;

  always #5 clk = ~clk;

  // Behavioural downstream jk_ff, starting in an arbitrary state.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_fb = force_q0 ? 1'b0 : q_ff;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
    .q_fb(q_fb), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending command queue plus the command currently driven.
  typedef struct {
    logic [1:0] op;
    int         len;
  } cmd_t;

  cmd_t       mq[$];
  logic [1:0] m_op;
  int         m_left;
  logic       m_q, m_known, m_err;
  bit         last_acc;

  task automatic model_reset();
    mq.delete();
    m_op    = 2'b00;
    m_left  = 0;
    m_q     = 1'b0;
    m_known = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic logic [3:0] exp_vec();
    logic [1:0] jk;
    logic       b, r;
    jk = (m_left > 0) ? m_op : 2'b00;
    b  = (m_left > 0) || (mq.size() > 0);
    r  = (mq.size() < DEPTH);
    return {jk, b, r};
  endfunction

  // One clock: drive at negedge, advance model at posedge, compare just after.
  task automatic step(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len);
    logic [1:0] jk_before;
    bit         acc;
    cmd_t       c;
`ifdef JKSEQ_CHECK_EN
    logic       qfb_s;
`endif
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
`ifdef JKSEQ_CHECK_EN
    qfb_s     = q_fb;
`endif
    jk_before = (m_left > 0) ? m_op : 2'b00;
    acc       = v && (mq.size() < DEPTH);
    @(posedge clk);
`ifdef JKSEQ_CHECK_EN
    if (m_known && (qfb_s !== m_q)) m_err = 1'b1;
    case (jk_before)
      2'b01:   m_q = 1'b0;
      2'b10:   m_q = 1'b1;
      2'b11:   m_q = ~m_q;
      default: m_q = m_q;
    endcase
    if (jk_before == 2'b01 || jk_before == 2'b10) m_known = 1'b1;
`endif
    if (m_left > 1) begin
      m_left--;
    end else if (mq.size() > 0) begin
      c      = mq.pop_front();
      m_op   = c.op;
      m_left = (c.len == 0) ? 1 : c.len;
    end else begin
      m_left = 0;
    end
    if (acc) begin
      c.op  = op;
      c.len = int'(len);
      mq.push_back(c);
    end
    last_acc = acc;
    #1;
    check("jk_busy_ready", {28'd0, j, k, busy, cmd_ready}, {28'd0, exp_vec()});
    check("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'($urandom), CNT_W'($urandom));
  endtask

  // Offer a command and hold it until accepted, bounded.
  task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] len);
    int n = 0;
    do begin
      step(1'b1, op, len);
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'd0, j, k, busy, cmd_ready}, 32'h1);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic             r_v;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_len;

  initial begin
    model_reset();
    last_acc = 1'b1;
    apply_reset();
    idle(2);

    // Single command latency
    push_cmd(2'b10, 4'd3);
    idle(6);

    // Back-to-back with no gap
    push_cmd(2'b01, 4'd2);
    push_cmd(2'b11, 4'd3);
    push_cmd(2'b00, 4'd1);
    idle(8);

    // Full FIFO and held command
    push_cmd(2'b10, 4'd15);
    push_cmd(2'b01, 4'd2);
    push_cmd(2'b11, 4'd3);
    push_cmd(2'b00, 4'd1);
    push_cmd(2'b10, 4'd2);
    push_cmd(2'b11, 4'd4);
    idle(40);

    // Length 0 and maximum
    push_cmd(2'b10, 4'd0);
    idle(3);
    push_cmd(2'b11, 4'd15);
    idle(18);

    // Checker: forced q_fb during a TOGGLE
    push_cmd(2'b10, 4'd2);
    push_cmd(2'b11, 4'd4);
    idle(2);
    force_q0 = 1'b1;
    idle(4);
    force_q0 = 1'b0;
    idle(3);
`ifdef JKSEQ_CHECK_EN
    check("err_sticky", {31'd0, err}, 32'd1);
`else
    check("err_disabled", {31'd0, err}, 32'd0);
`endif
    apply_reset();

    // Reset mid-run aborts immediately
    push_cmd(2'b10, 4'd8);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {28'd0, j, k, busy, cmd_ready}, 32'h1);
    check("midrst_err", {31'd0, err}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic; rejected commands are held unchanged
    r_v = 1'b0;
    r_op = 2'b00;
    r_len = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(r_v && !last_acc)) begin
        r_v   = ($urandom_range(0, 2) != 0);
        r_op  = 2'($urandom);
        r_len = ($urandom_range(0, 7) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 4));
      end
      step(r_v, r_op, r_len);
    end
    idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
